// File: rtl/vision_test_if.sv
`default_nettype none
// ============================================================================
// Module   : vision_test_if
// Brief    : Handshake bundle between the vision acuity test controller and
//            its environment (random generator, subject keypad, display).
// Revision : 1.0
// ============================================================================
interface vision_test_if;
  logic       restart;
  logic       dir_valid;
  logic [2:0] dir_in;
  logic [2:0] ran_num;
  logic       ran_req;
  logic [2:0] show_dir;
  logic [3:0] level;
  logic [2:0] trial_cnt;
  logic [2:0] correct_cnt;
  logic       judge_pulse;
  logic       judge_ok;
  logic       test_done;
  logic [3:0] final_level;

  modport master (
    output restart, dir_valid, dir_in, ran_num,
    input  ran_req, show_dir, level, trial_cnt, correct_cnt,
           judge_pulse, judge_ok, test_done, final_level
  );

  modport slave (
    input  restart, dir_valid, dir_in, ran_num,
    output ran_req, show_dir, level, trial_cnt, correct_cnt,
           judge_pulse, judge_ok, test_done, final_level
  );
endinterface
`default_nettype wire

// File: rtl/vision_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vision_test_ctrl
// Brief    : Staircase visual-acuity test sequencer. Optional response timeout
//            enabled by defining RESP_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module vision_test_ctrl #(
  parameter int LEVELS      = 10,
  parameter int TRIALS      = 4,
  parameter int PASS_CNT    = 3,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic         clk,
  input  logic         rst,
  vision_test_if.slave bus
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_DRAW  = 3'd1;
  localparam logic [2:0] c_CAPT  = 3'd2;
  localparam logic [2:0] c_WAIT  = 3'd3;
  localparam logic [2:0] c_JUDGE = 3'd4;
  localparam logic [2:0] c_DONE  = 3'd5;

  localparam logic [3:0] c_TRIALS = 4'(TRIALS);
  localparam logic [3:0] c_PASS   = 4'(PASS_CNT);
  localparam logic [3:0] c_LAST   = 4'(LEVELS - 1);

  logic [2:0] r_state;
  logic [2:0] r_show;
  logic [2:0] r_ans;
  logic [3:0] r_level;
  logic [2:0] r_trial;
  logic [2:0] r_correct;
  logic [3:0] r_final;

  logic       w_ok;
  logic [3:0] w_trial_nx;
  logic [3:0] w_corr_nx;
  logic       w_ran_legal;
  logic       w_dir_legal;
  logic       w_tmo;

  assign w_ok        = (r_ans == r_show);
  assign w_trial_nx  = {1'b0, r_trial} + 4'd1;
  assign w_corr_nx   = {1'b0, r_correct} + {3'b000, w_ok};
  assign w_ran_legal = (bus.ran_num != 3'd0) && (bus.ran_num <= 3'd4);
  assign w_dir_legal = bus.dir_valid && (bus.dir_in != 3'd0) && (bus.dir_in <= 3'd4);

`ifdef RESP_TIMEOUT_EN
  localparam int c_TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [c_TW-1:0] r_tmo;

  // Held at zero outside WAIT, so it restarts from zero on every WAIT entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_tmo <= '0;
    else if (r_state != c_WAIT || bus.restart)
      r_tmo <= '0;
    else
      r_tmo <= r_tmo + c_TW'(1);
  end

  assign w_tmo = (r_tmo == c_TW'(TIMEOUT_CYC - 1));
`else
  localparam int c_unused_timeout = TIMEOUT_CYC;
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_show    <= 3'd0;
      r_ans     <= 3'd0;
      r_level   <= 4'd0;
      r_trial   <= 3'd0;
      r_correct <= 3'd0;
      r_final   <= 4'd0;
    end else if (bus.restart) begin
      r_state   <= c_DRAW;
      r_show    <= 3'd0;
      r_level   <= 4'd0;
      r_trial   <= 3'd0;
      r_correct <= 3'd0;
      r_final   <= 4'd0;
    end else begin
      case (r_state)
        c_DRAW: r_state <= c_CAPT;
        c_CAPT: begin
          if (w_ran_legal) begin
            r_show  <= bus.ran_num;
            r_state <= c_WAIT;
          end else begin
            r_state <= c_DRAW;
          end
        end
        c_WAIT: begin
          if (w_dir_legal) begin
            r_ans   <= bus.dir_in;
            r_state <= c_JUDGE;
          end else if (w_tmo) begin
            // Zero never matches a displayed direction, so a timeout judges wrong.
            r_ans   <= 3'd0;
            r_state <= c_JUDGE;
          end
        end
        c_JUDGE: begin
          r_show    <= 3'd0;
          r_trial   <= w_trial_nx[2:0];
          r_correct <= w_corr_nx[2:0];
          if (w_trial_nx < c_TRIALS) begin
            r_state <= c_DRAW;
          end else if (w_corr_nx >= c_PASS) begin
            r_final <= r_level + 4'd1;
            if (r_level == c_LAST) begin
              r_state <= c_DONE;
            end else begin
              r_level   <= r_level + 4'd1;
              r_trial   <= 3'd0;
              r_correct <= 3'd0;
              r_state   <= c_DRAW;
            end
          end else begin
            r_state <= c_DONE;
          end
        end
        c_IDLE, c_DONE: r_state <= r_state;
        default:        r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.ran_req     = (r_state == c_DRAW);
  assign bus.judge_pulse = (r_state == c_JUDGE);
  assign bus.judge_ok    = (r_state == c_JUDGE) && w_ok;
  assign bus.test_done   = (r_state == c_DONE);
  assign bus.show_dir    = r_show;
  assign bus.level       = r_level;
  assign bus.trial_cnt   = r_trial;
  assign bus.correct_cnt = r_correct;
  assign bus.final_level = r_final;

endmodule
`default_nettype wire

// File: tb/tb_vision_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vision_test_ctrl
// Brief    : Scoreboard bench for vision_test_ctrl (LEVELS=2, TRIALS=4,
//            PASS_CNT=3, TIMEOUT_CYC=10).
// Revision : 1.0
// ============================================================================
module tb_vision_test_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic sb_q[$];

  vision_test_if bus ();

  vision_test_ctrl #(
    .LEVELS(2), .TRIALS(4), .PASS_CNT(3), .TIMEOUT_CYC(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.judge_pulse) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_judge", 32'd1, 32'd0);
      end else begin
        logic e;
        e = sb_q.pop_front();
        check_eq("judge_ok", {31'd0, bus.judge_ok}, {31'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_restart();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
  endtask

  task automatic wait_show(output int n);
    n = 0;
    while (bus.show_dir == 3'd0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check_eq("wait_show_timeout", 32'd0, 32'd1);
  endtask

  // Answer in WAIT, then step through JUDGE so the caller sees the next state.
  task automatic answer(input logic [2:0] d, input logic exp_ok);
    sb_q.push_back(exp_ok);
    bus.dir_in    = d;
    bus.dir_valid = 1'b1;
    tick();
    bus.dir_valid = 1'b0;
    tick();
  endtask

  function automatic logic [20:0] all_outs();
    return {bus.ran_req, bus.show_dir, bus.level, bus.trial_cnt, bus.correct_cnt,
            bus.judge_pulse, bus.judge_ok, bus.test_done, bus.final_level};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int reqs;
    logic [2:0] seen_show;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.restart = 1'b0;
    bus.dir_valid = 1'b0;
    bus.dir_in = 3'd0;
    bus.ran_num = 3'd2;
    repeat (3) tick();
    check_eq("reset_outs", {11'd0, all_outs()}, 32'd0);
    rst = 1'b0;

    // Idle: stray answers ignored, generator never loaded.
    bus.dir_in = 3'd2; bus.dir_valid = 1'b1;
    tick();
    bus.dir_valid = 1'b0;
    reqs = 0;
    repeat (5) begin @(negedge clk); reqs += bus.ran_req; tick(); end
    check_eq("idle_no_req", reqs, 0);

    // Level 0 all correct -> advance to level 1.
    pulse_restart();
    check_eq("restart_ran_req", {31'd0, bus.ran_req}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      wait_show(n);
      if (i == 1) check_eq("redisplay_lat", n, 2);
      check_eq("show_dir_l0", {29'd0, bus.show_dir}, 32'd2);
      answer(3'd2, 1'b1);
    end
    check_eq("level_after_pass", {28'd0, bus.level}, 32'd1);
    check_eq("final_after_l0", {28'd0, bus.final_level}, 32'd1);
    check_eq("trial_clr", {29'd0, bus.trial_cnt}, 32'd0);
    check_eq("ran_req_next", {31'd0, bus.ran_req}, 32'd1);

    // Illegal random number forces redraws without entering WAIT.
    bus.ran_num = 3'd0;
    reqs = 0;
    seen_show = 3'd0;
    repeat (6) begin
      @(negedge clk);
      reqs += bus.ran_req;
      seen_show |= bus.show_dir;
      tick();
    end
    check_eq("redraw_reqs", reqs, 3);
    check_eq("redraw_no_wait", {29'd0, seen_show}, 32'd0);
    bus.ran_num = 3'd3;
    wait_show(n);
    check_eq("show_dir_l1", {29'd0, bus.show_dir}, 32'd3);

    // Illegal answer direction ignored.
    bus.dir_in = 3'd5; bus.dir_valid = 1'b1;
    tick();
    bus.dir_valid = 1'b0;
    tick();
    check_eq("bad_dir_trial", {29'd0, bus.trial_cnt}, 32'd0);
    check_eq("bad_dir_show", {29'd0, bus.show_dir}, 32'd3);

    // Last level all correct -> DONE with final_level = LEVELS.
    for (int i = 0; i < 4; i++) begin
      wait_show(n);
      answer(3'd3, 1'b1);
    end
    check_eq("done_last", {31'd0, bus.test_done}, 32'd1);
    check_eq("final_all", {28'd0, bus.final_level}, 32'd2);
    check_eq("done_show_blank", {29'd0, bus.show_dir}, 32'd0);

    // Level 0 fail: correct, wrong, wrong, wrong.
    bus.ran_num = 3'd1;
    pulse_restart();
    check_eq("restart_clr_done", {31'd0, bus.test_done}, 32'd0);
    check_eq("restart_clr_final", {28'd0, bus.final_level}, 32'd0);
    wait_show(n); answer(3'd1, 1'b1);
    wait_show(n); answer(3'd2, 1'b0);
    wait_show(n); answer(3'd3, 1'b0);
    wait_show(n); answer(3'd4, 1'b0);
    check_eq("fail_done", {31'd0, bus.test_done}, 32'd1);
    check_eq("fail_final", {28'd0, bus.final_level}, 32'd0);
    check_eq("fail_trials", {29'd0, bus.trial_cnt}, 32'd4);
    check_eq("fail_correct", {29'd0, bus.correct_cnt}, 32'd1);

    // Restart coincident with an answer aborts without a verdict.
    pulse_restart();
    wait_show(n); answer(3'd1, 1'b1);
    wait_show(n);
    bus.restart = 1'b1; bus.dir_in = 3'd1; bus.dir_valid = 1'b1;
    tick();
    bus.restart = 1'b0; bus.dir_valid = 1'b0;
    check_eq("abort_draw", {31'd0, bus.ran_req}, 32'd1);
    check_eq("abort_trial", {29'd0, bus.trial_cnt}, 32'd0);
    check_eq("abort_correct", {29'd0, bus.correct_cnt}, 32'd0);
    check_eq("abort_show", {29'd0, bus.show_dir}, 32'd0);

    // Asynchronous reset in WAIT.
    wait_show(n);
    check_eq("pre_rst_show", {29'd0, bus.show_dir}, 32'd1);
    rst = 1'b1;
    #2;
    check_eq("async_rst_outs", {11'd0, all_outs()}, 32'd0);
    tick();
    rst = 1'b0;
    reqs = 0;
    repeat (8) begin @(negedge clk); reqs += bus.ran_req; tick(); end
    check_eq("post_rst_no_req", reqs, 0);

`ifdef RESP_TIMEOUT_EN
    // No answer: verdict (wrong) after exactly 10 WAIT cycles.
    pulse_restart();
    wait_show(n);
    sb_q.push_back(1'b0);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus.judge_pulse) break;
      n++;
    end
    check_eq("timeout_cycles", n, 10);
    tick();
    tick();
`endif

    check_eq("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
